pwm_fade: RTL
=============

PWM_FADE -- requirements
Module: pwm_fade

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of all data, duty, overflow and step quantities.
REQ-002 i_clk  input  1  single clock; all logic on rising edge.
REQ-003 i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_we  input  1  bus write strobe, one cycle per write.
REQ-005 i_addr  input  3  register word address.
REQ-006 i_wdata  input  DATA_WIDTH  bus write data.
REQ-007 o_rdata  output  DATA_WIDTH  registered read data for i_addr.
REQ-008 o_en  output  1  enable to downstream PWM stage.
REQ-009 o_dc  output  DATA_WIDTH  current duty value to PWM stage.
REQ-010 o_ovf  output  DATA_WIDTH  period overflow value to PWM stage.
REQ-011 o_busy  output  1  high while a ramp is in progress.
REQ-012 o_irq  output  1  ramp-complete interrupt (see Configuration).

Function
REQ-013 Register map: 0 CTRL (bit0 EN, bit1 START, write-1 pulse), 1 OVF, 2 TARGET, 3 STEP, 4 INTERVAL, 5 STATUS (read: bit0 busy, bit1 irq flag; write any value: clear irq), 6 CURDC (read-only); 7 reads 0, writes ignored.
REQ-014 Writes take effect on the clock edge of i_we; o_en/o_ovf reflect CTRL.EN/OVF one cycle after the write.
REQ-015 o_rdata updates one cycle after i_addr is presented, regardless of i_we.
REQ-016 Effective target = min(TARGET, OVF), re-evaluated every cycle.
REQ-017 States IDLE, UP, DOWN; START in IDLE enters UP if target > o_dc, DOWN if target < o_dc, else stays IDLE and sets the done event.
REQ-018 Step tick: cycle counter runs 0..INTERVAL, ticks on reaching INTERVAL then wraps to 0; INTERVAL=0 ticks every cycle; counter cleared on entry to UP/DOWN.
REQ-019 On each tick in UP: o_dc <= min(o_dc + STEP, target); in DOWN: o_dc <= max(o_dc - STEP, target); no wrap-around, computed at DATA_WIDTH+1 bits.
REQ-020 STEP=0 is treated as 1.
REQ-021 When o_dc reaches target, return to IDLE on the same edge and raise done event.
REQ-022 TARGET or OVF change during a ramp: direction re-evaluated at next tick; if o_dc already past new target, o_dc is set to target and the ramp ends.
REQ-023 START while UP/DOWN is ignored.
REQ-024 Write to CURDC address is ignored; o_dc changes only by ramp or reset.
REQ-025 o_busy = state is UP or DOWN.
REQ-026 CTRL.EN=0 does not stop the ramp; it only gates o_en.

Reset
REQ-027 i_rst_n low at a clock edge forces: all registers 0, state IDLE, o_dc 0, o_ovf 0, o_en 0, o_busy 0, o_irq 0, o_rdata 0.
REQ-028 Reset mid-ramp aborts the ramp; reset has priority over a simultaneous write.

Configuration
REQ-029 Macro PWM_FADE_IRQ_EN defined: done event sets a sticky irq flag driving o_irq until STATUS write; a done event and STATUS write in the same cycle leave the flag set.
REQ-030 Macro undefined: no flag logic, o_irq tied 0, STATUS bit1 reads 0.

Structure
REQ-031 Package pwm_fade_pkg holds register address constants, CTRL bit indices and the state enum.
REQ-032 Sub-module fade_tick holds the interval counter and produces the one-cycle tick, with a clear input.

Verification
REQ-033 Reset then read all addresses -> all 0, outputs 0.
REQ-034 OVF=100, STEP=10, INTERVAL=3, TARGET=35, START -> o_dc 10,20,30,35 every 4 cycles, busy falls with 35.
REQ-035 From o_dc=35, TARGET=0, STEP=0, START -> o_dc decrements by 1 every 4 cycles to 0.
REQ-036 TARGET=200, OVF=50, START -> ramp ends at 50; mid-ramp OVF=20 -> o_dc=20 next tick, IDLE.
REQ-037 IRQ build: ramp completes -> o_irq=1 held; STATUS write -> 0; non-IRQ build o_irq stays 0.
REQ-038 Reset asserted mid-ramp -> next cycle o_dc=0, o_busy=0, state IDLE.

Source files
------------

// File: rtl/pwm_fade_pkg.sv
// Shared definitions for the PWM fade controller: register addresses, CTRL/STATUS
// bit positions and the ramp state encoding.
package pwm_fade_pkg;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_OVF      = 3'd1;
  localparam logic [2:0] ADDR_TARGET   = 3'd2;
  localparam logic [2:0] ADDR_STEP     = 3'd3;
  localparam logic [2:0] ADDR_INTERVAL = 3'd4;
  localparam logic [2:0] ADDR_STATUS   = 3'd5;
  localparam logic [2:0] ADDR_CURDC    = 3'd6;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_START_BIT  = 1;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_IRQ_BIT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } fade_state_e;

endpackage

// File: rtl/fade_tick.sv
// Interval counter for the fade ramp: emits a one-cycle tick every INTERVAL+1
// cycles; i_clear restarts the count from zero.
module fade_tick #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_interval,
  output logic                  o_tick
);

  logic [DATA_WIDTH-1:0] cnt_reg;
  logic [DATA_WIDTH-1:0] cnt_next;

  // >= rather than == so a shortened interval cannot strand the counter above it
  assign o_tick = (cnt_reg >= i_interval);

  always_comb begin
    cnt_next = cnt_reg + DATA_WIDTH'(1);
    if (i_clear || o_tick) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/pwm_fade.sv
// Register-mapped duty-cycle fader feeding a downstream PWM stage.
// Optional ramp-complete interrupt flag is built when PWM_FADE_IRQ_EN is defined.
module pwm_fade
  import pwm_fade_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [2:0]            i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_en,
  output logic [DATA_WIDTH-1:0] o_dc,
  output logic [DATA_WIDTH-1:0] o_ovf,
  output logic                  o_busy,
  output logic                  o_irq
);

  localparam int DW = DATA_WIDTH;

  logic          en_reg;
  logic [DW-1:0] ovf_reg;
  logic [DW-1:0] target_reg;
  logic [DW-1:0] step_reg;
  logic [DW-1:0] interval_reg;
  logic [DW-1:0] dc_reg;
  logic [DW-1:0] dc_next;
  logic [DW-1:0] rdata_reg;
  logic [DW-1:0] rdata_next;
  fade_state_e   state_reg;
  fade_state_e   state_next;

  logic          start;
  logic          done;
  logic          tick;
  logic          busy;
  logic          irq_flag;
  logic [DW-1:0] target_eff;
  logic [DW-1:0] step_eff;
  logic [DW:0]   sum_ext;
  logic [DW:0]   diff_ext;
  logic [DW-1:0] up_val;
  logic [DW-1:0] down_val;

  assign start = i_we && (i_addr == ADDR_CTRL) && i_wdata[CTRL_START_BIT];
  assign busy  = (state_reg != ST_IDLE);

  assign target_eff = (target_reg < ovf_reg) ? target_reg : ovf_reg;
  assign step_eff   = (step_reg == '0) ? DW'(1) : step_reg;

  // One extra bit so saturation is decided before any wrap-around
  assign sum_ext  = {1'b0, dc_reg} + {1'b0, step_eff};
  assign diff_ext = {1'b0, dc_reg} - {1'b0, step_eff};

  always_comb begin
    up_val = sum_ext[DW-1:0];
    if ((dc_reg >= target_eff) || (sum_ext >= {1'b0, target_eff})) begin
      up_val = target_eff;
    end
  end

  always_comb begin
    down_val = diff_ext[DW-1:0];
    if ((dc_reg <= target_eff) || diff_ext[DW] || (diff_ext[DW-1:0] < target_eff)) begin
      down_val = target_eff;
    end
  end

  fade_tick #(
    .DATA_WIDTH (DW)
  ) u_fade_tick (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (state_reg == ST_IDLE),
    .i_interval (interval_reg),
    .o_tick     (tick)
  );

  always_comb begin
    state_next = state_reg;
    dc_next    = dc_reg;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (target_eff > dc_reg) begin
            state_next = ST_UP;
          end else if (target_eff < dc_reg) begin
            state_next = ST_DOWN;
          end else begin
            done = 1'b1;
          end
        end
      end
      ST_UP: begin
        if (tick) begin
          dc_next = up_val;
          if (up_val == target_eff) begin
            state_next = ST_IDLE;
            done       = 1'b1;
          end
        end
      end
      ST_DOWN: begin
        if (tick) begin
          dc_next = down_val;
          if (down_val == target_eff) begin
            state_next = ST_IDLE;
            done       = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    rdata_next = '0;
    case (i_addr)
      ADDR_CTRL:     rdata_next[CTRL_EN_BIT] = en_reg;
      ADDR_OVF:      rdata_next = ovf_reg;
      ADDR_TARGET:   rdata_next = target_reg;
      ADDR_STEP:     rdata_next = step_reg;
      ADDR_INTERVAL: rdata_next = interval_reg;
      ADDR_STATUS: begin
        rdata_next[STATUS_BUSY_BIT] = busy;
        rdata_next[STATUS_IRQ_BIT]  = irq_flag;
      end
      ADDR_CURDC:    rdata_next = dc_reg;
      default:       rdata_next = '0;
    endcase
  end

  // START is a pulse and CURDC is read-only, so neither has backing storage here
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      en_reg       <= 1'b0;
      ovf_reg      <= '0;
      target_reg   <= '0;
      step_reg     <= '0;
      interval_reg <= '0;
      dc_reg       <= '0;
      rdata_reg    <= '0;
      state_reg    <= ST_IDLE;
    end else begin
      if (i_we) begin
        case (i_addr)
          ADDR_CTRL:     en_reg       <= i_wdata[CTRL_EN_BIT];
          ADDR_OVF:      ovf_reg      <= i_wdata;
          ADDR_TARGET:   target_reg   <= i_wdata;
          ADDR_STEP:     step_reg     <= i_wdata;
          ADDR_INTERVAL: interval_reg <= i_wdata;
          default:       ;
        endcase
      end
      dc_reg    <= dc_next;
      rdata_reg <= rdata_next;
      state_reg <= state_next;
    end
  end

`ifdef PWM_FADE_IRQ_EN
  logic irq_reg;

  // A completion in the same cycle as a clear wins, so no event is lost
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      irq_reg <= 1'b0;
    end else if (done) begin
      irq_reg <= 1'b1;
    end else if (i_we && (i_addr == ADDR_STATUS)) begin
      irq_reg <= 1'b0;
    end
  end

  assign irq_flag = irq_reg;
`else
  logic done_unused;

  assign done_unused = done;
  assign irq_flag    = 1'b0;
`endif

  assign o_rdata = rdata_reg;
  assign o_en    = en_reg;
  assign o_dc    = dc_reg;
  assign o_ovf   = ovf_reg;
  assign o_busy  = busy;
  assign o_irq   = irq_flag;

endmodule
